wr_edge_fifo: RTL and testbench

//  Downstream consumer of the write-strobe stage. It qualifies i_WR, which may be a
//  1-cycle pulse or a multi-cycle level, into single push events. Each push captures
//  i_DATA into a small FIFO that a later stage drains over a valid/ready handshake.

---
 rtl/wr_edge_fifo_if.sv | 27 ++
 rtl/wr_edge_fifo.sv | 74 +++++++
 tb/tb_wr_edge_fifo.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/wr_edge_fifo_if.sv
// Bus bundle for wr_edge_fifo: write-strobe input, FWFT read handshake and debug status.
// Read handshake: o_VALID is high whenever o_RD_DATA holds a word. A word is consumed
// (popped) on every rising clock edge where o_VALID and i_READY are both high.
interface wr_edge_fifo_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
);
  logic              i_WR;
  logic [DATA_W-1:0] i_DATA;
  logic [DATA_W-1:0] o_RD_DATA;
  logic              o_VALID;
  logic              i_READY;
  logic              o_FULL;
  logic              o_EMPTY;
  logic [ADDR_W:0]   o_COUNT;
  logic              o_OVF;

  modport slave (
    input  i_WR, i_DATA, i_READY,
    output o_RD_DATA, o_VALID, o_FULL, o_EMPTY, o_COUNT, o_OVF
  );

  modport master (
    output i_WR, i_DATA, i_READY,
    input  o_RD_DATA, o_VALID, o_FULL, o_EMPTY, o_COUNT, o_OVF
  );
endinterface

// File: rtl/wr_edge_fifo.sv
// Small FWFT FIFO whose pushes come from rising edges of i_WR (one push per pulse or level).
// Define WR_LEVEL_PUSH_EN to push on every cycle i_WR is high instead.
module wr_edge_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic          i_CLK,
  input  logic          i_RST,
  wr_edge_fifo_if.slave io_bus
);
  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_ovf;

  logic w_push_req;
  logic w_push;
  logic w_pop;
  logic w_full;
  logic w_empty;

`ifdef WR_LEVEL_PUSH_EN
  assign w_push_req = io_bus.i_WR;
`else
  logic r_wr_q;

  // Resets high so a strobe already asserted across reset release is not taken as an edge.
  always_ff @(posedge i_CLK) begin
    if (i_RST) r_wr_q <= 1'b1;
    else       r_wr_q <= io_bus.i_WR;
  end

  assign w_push_req = io_bus.i_WR & ~r_wr_q;
`endif

  assign w_full  = (r_count == LP_DEPTH);
  assign w_empty = (r_count == '0);
  assign w_pop   = ~w_empty & io_bus.i_READY;
  // A full FIFO still accepts a push when a word leaves in the same cycle.
  assign w_push  = w_push_req & (~w_full | w_pop);

  always_ff @(posedge i_CLK) begin
    if (w_push && !i_RST) r_mem[r_wr_ptr] <= io_bus.i_DATA;
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_push_req && w_full && !w_pop) r_ovf <= 1'b1;
    end
  end

  assign io_bus.o_COUNT   = r_count;
  assign io_bus.o_FULL    = w_full;
  assign io_bus.o_EMPTY   = w_empty;
  assign io_bus.o_VALID   = ~w_empty;
  assign io_bus.o_OVF     = r_ovf;
  assign io_bus.o_RD_DATA = w_empty ? '0 : r_mem[r_rd_ptr];
endmodule

// File: tb/tb_wr_edge_fifo.sv
// Directed self-checking bench for wr_edge_fifo (default edge-qualified build).
module tb_wr_edge_fifo;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;

  logic i_clk;
  logic i_rst;
  int   n_tests;
  int   n_fail;
  logic [DATA_W-1:0] exp_q[$];

  wr_edge_fifo_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  wr_edge_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .i_CLK  (i_clk),
    .i_RST  (i_rst),
    .io_bus (bus)
  );

  // clock / reset
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Outputs depend only on state, so checking #1 after the edge is stable.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic do_reset(input int cycles);
    i_rst = 1'b1;
    bus.i_WR = 1'b0;
    bus.i_READY = 1'b0;
    repeat (cycles) tick();
    i_rst = 1'b0;
    tick();
    exp_q.delete();
  endtask

  task automatic pulse(input logic [DATA_W-1:0] d);
    bus.i_WR = 1'b1;
    bus.i_DATA = d;
    tick();
    bus.i_WR = 1'b0;
    tick();
  endtask

  // scoreboard drain: every expected word must appear at the head, in order
  task automatic drain(input string tag);
    while (exp_q.size() != 0) begin
      check({tag, "_valid"}, 32'(bus.o_VALID), 1);
      check({tag, "_data"}, 32'(bus.o_RD_DATA), 32'(exp_q.pop_front()));
      bus.i_READY = 1'b1;
      tick();
      bus.i_READY = 1'b0;
    end
    check({tag, "_empty"}, 32'(bus.o_EMPTY), 1);
    check({tag, "_count0"}, 32'(bus.o_COUNT), 0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    i_rst = 1'b1;
    bus.i_WR = 1'b1;
    bus.i_DATA = '0;
    bus.i_READY = 1'b0;

    // T1: reset with i_WR held high; release with i_WR still high gives no push
    tick();
    tick();
    check("t1_count", 32'(bus.o_COUNT), 0);
    check("t1_empty", 32'(bus.o_EMPTY), 1);
    check("t1_full", 32'(bus.o_FULL), 0);
    check("t1_ovf", 32'(bus.o_OVF), 0);
    check("t1_valid", 32'(bus.o_VALID), 0);
    check("t1_rdata", 32'(bus.o_RD_DATA), 0);
    i_rst = 1'b0;
    bus.i_DATA = 8'hEE;
    tick();
    tick();
    check("t1_nopush", 32'(bus.o_COUNT), 0);
    bus.i_WR = 1'b0;
    tick();

    // T2: pulse, pulse, 3-cycle level -> 3 pushes
    bus.i_WR = 1'b1;
    bus.i_DATA = 8'hA1;
    tick();
    check("t2_lat_valid", 32'(bus.o_VALID), 1);
    check("t2_lat_data", 32'(bus.o_RD_DATA), 32'h A1);
    bus.i_WR = 1'b0;
    tick();
    pulse(8'hB2);
    bus.i_WR = 1'b1;
    bus.i_DATA = 8'hC3; tick();
    bus.i_DATA = 8'hC4; tick();
    bus.i_DATA = 8'hC5; tick();
    bus.i_WR = 1'b0;
    tick();
    check("t2_count", 32'(bus.o_COUNT), 3);
    exp_q.push_back(8'hA1); exp_q.push_back(8'hB2); exp_q.push_back(8'hC3);
    drain("t2");

    // T3: overflow on the 5th edge, sticky afterwards
    for (int i = 1; i <= 4; i++) pulse(DATA_W'(i));
    check("t3_full", 32'(bus.o_FULL), 1);
    check("t3_count4", 32'(bus.o_COUNT), 4);
    check("t3_ovf_pre", 32'(bus.o_OVF), 0);
    pulse(8'h05);
    check("t3_ovf", 32'(bus.o_OVF), 1);
    check("t3_count_hold", 32'(bus.o_COUNT), 4);
    for (int i = 1; i <= 4; i++) exp_q.push_back(DATA_W'(i));
    drain("t3");
    check("t3_ovf_sticky", 32'(bus.o_OVF), 1);
    do_reset(1);
    check("t3_ovf_clr", 32'(bus.o_OVF), 0);

    // T4: push while full with a simultaneous pop
    pulse(8'h11); pulse(8'h22); pulse(8'h33); pulse(8'h44);
    bus.i_WR = 1'b1;
    bus.i_DATA = 8'h55;
    bus.i_READY = 1'b1;
    tick();
    bus.i_WR = 1'b0;
    bus.i_READY = 1'b0;
    check("t4_count", 32'(bus.o_COUNT), 4);
    check("t4_full", 32'(bus.o_FULL), 1);
    check("t4_ovf", 32'(bus.o_OVF), 0);
    check("t4_head", 32'(bus.o_RD_DATA), 32'h22);
    tick();
    exp_q.push_back(8'h22); exp_q.push_back(8'h33);
    exp_q.push_back(8'h44); exp_q.push_back(8'h55);
    drain("t4");

    // T5: 10 push/pop pairs with i_READY held high; pointers wrap twice
    bus.i_READY = 1'b1;
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(DATA_W'(8'h30 + i));
      bus.i_WR = 1'b1;
      bus.i_DATA = DATA_W'(8'h30 + i);
      tick();
      check("t5_valid", 32'(bus.o_VALID), 1);
      check("t5_data", 32'(bus.o_RD_DATA), 32'(exp_q.pop_front()));
      check("t5_le1", 32'(bus.o_COUNT <= 1), 1);
      bus.i_WR = 1'b0;
      tick();
      check("t5_popped", 32'(bus.o_COUNT), 0);
    end
    bus.i_READY = 1'b0;

    // T6: reset mid-operation at count 3
    pulse(8'h61); pulse(8'h62); pulse(8'h63);
    check("t6_count3", 32'(bus.o_COUNT), 3);
    i_rst = 1'b1;
    tick();
    check("t6_valid", 32'(bus.o_VALID), 0);
    check("t6_count", 32'(bus.o_COUNT), 0);
    check("t6_rdata", 32'(bus.o_RD_DATA), 0);
    i_rst = 1'b0;
    tick();
    pulse(8'h77);
    exp_q.push_back(8'h77);
    drain("t6");

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
